// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit that owns the HI/LO register pair.
//   An accepted mult/multu/div/divu computes its 64-bit result at once into
//   pending registers. The unit then stays busy for a fixed number of cycles
//   and commits the result to HI/LO on the last edge. mthi/mtlo write HI or
//   LO at the end of the cycle in which they are accepted.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high
//   md_op     in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                  7 reserved (none)
//   rs_val    in   dividend / multiplicand / mthi-mtlo source
//   rt_val    in   divisor / multiplier
//   cancel    in   exception taken: the op presented this cycle is dropped
//   md_start  out  combinational, a mult/div is accepted this cycle
//   busy      out  registered, a computation is pending
//   hi, lo    out  architectural HI/LO registers
//
// State | meaning
// IDLE  | no computation pending, ops accepted
// BUSY  | result pending, counter runs down to terminal count 1
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        md_start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi, pend_lo;
    logic             pend_wr;

    logic        is_md, is_div, is_signed, accept_mt, last;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] dvd, dvs, quo, rem, quo_fix, rem_fix;
    logic        dvs_zero;
    logic [63:0] result;

    // control
    always_comb begin
        is_md     = (md_op >= 3'd1) && (md_op <= 3'd4);
        is_div    = (md_op == 3'd3) || (md_op == 3'd4);
        is_signed = (md_op == 3'd1) || (md_op == 3'd3);
        md_start  = !reset && (state == IDLE) && !cancel && is_md;
        accept_mt = (state == IDLE) && !cancel && ((md_op == 3'd5) || (md_op == 3'd6));
        last      = (state == BUSY) && (cnt == CNT_W'(1));

        state_nxt = state;
        case (state)
            IDLE: if (md_start) state_nxt = BUSY;
            BUSY: if (last)     state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // datapath: one multiplier and one unsigned divider shared by the
    // signed/unsigned variants
    always_comb begin
        mul_a = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        mul_b = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        prod  = mul_a * mul_b;

        // Signed divide runs on magnitudes, then re-applies signs. This also
        // makes 0x80000000 / -1 wrap to 0x80000000 without overflow trouble.
        dvd      = (is_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        dvs      = (is_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        dvs_zero = (rt_val == 32'd0);
        quo      = dvs_zero ? 32'd0 : dvd / dvs;
        rem      = dvs_zero ? 32'd0 : dvd % dvs;
        quo_fix  = (is_signed && (rs_val[31] ^ rt_val[31])) ? (32'd0 - quo) : quo;
        rem_fix  = (is_signed && rs_val[31]) ? (32'd0 - rem) : rem;

        result = is_div ? {rem_fix, quo_fix} : prod;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (md_start) begin
                cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi <= result[63:32];
                pend_lo <= result[31:0];
                // a zero divisor burns the busy period but commits nothing
                pend_wr <= !(is_div && dvs_zero);
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (last && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (accept_mt) begin
                if (md_op == 3'd5) hi <= rs_val;
                else               lo <= rs_val;
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset input 1: reset is synchronous and active-high.
REQ-005 SHALL have port md_op input 3: EX-stage op; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 SHALL have port rs_val input 32: forwarded rs operand (dividend, multiplicand, mthi/mtlo source).
REQ-007 SHALL have port rt_val input 32: forwarded rt operand (divisor, multiplier).
REQ-008 SHALL have port cancel input 1: an exception/interrupt is being taken; the EX op this cycle must not take effect.
REQ-009 SHALL have port md_start output 1: combinational; 1 when a mult/multu/div/divu is accepted this cycle.
REQ-010 SHALL have port busy output 1: registered; 1 while a computation is pending.
REQ-011 SHALL have port hi output 32: current HI register.
REQ-012 SHALL have port lo output 32: current LO register.

Function
REQ-013 SHALL have two states, IDLE (busy=0) and BUSY (busy=1), plus a down-counter of at least 4 bits.
REQ-014 SHALL accept an op only when state=IDLE, cancel=0 and md_op is 1..6. md_start=1 only for accepted ops 1..4.
REQ-015 SHALL, on accepting op 1..4 in cycle T, compute the 64-bit result from the rs_val/rt_val sampled at T into pending registers, enter BUSY, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 SHALL hold busy=1 for exactly N cycles (T+1..T+N). On the edge ending cycle T+N it SHALL write the pending result to HI/LO and return to IDLE, so new HI/LO is visible and busy=0 from cycle T+N+1.
REQ-017 SHALL hold HI/LO at their old values throughout BUSY.
REQ-018 SHALL compute mult as a signed 32x32->64 product and multu as unsigned, with HI=[63:32] and LO=[31:0].
REQ-019 SHALL compute div as signed: LO=quotient truncated toward zero, HI=remainder with the dividend's sign. divu SHALL use the unsigned quotient/remainder.
REQ-020 SHALL make div of 0x80000000 by 0xFFFFFFFF give LO=0x80000000, HI=0.
REQ-021 SHALL handle a zero divisor by running the full DIV_CYCLES busy period, then leaving HI and LO unchanged.
REQ-022 SHALL, for mthi/mtlo accepted in IDLE, write rs_val to HI or LO at the end of that cycle, with no busy period.
REQ-023 SHALL ignore any md_op presented while busy=1 (no state change). Upstream stalls; the bench flags this as an error.
REQ-024 SHALL make cancel=1 suppress acceptance in the same cycle only. It SHALL NOT abort a computation already in BUSY, which completes normally.
REQ-025 SHALL accept a new op in the same cycle busy falls to 0 (cycle T+N+1).

Reset
REQ-026 SHALL, when reset=1 at an edge, set HI=0, LO=0, busy=0, state=IDLE, counter=0, pending=0, overriding any op or completion in that cycle.
REQ-027 SHALL, on reset mid-BUSY, discard the pending result; it is never committed later.
REQ-028 SHALL keep md_start=0 while reset=1.

Verification
REQ-029 SHALL be verified with: mult rs=0xFFFFFFFF, rt=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 SHALL be verified with: div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu rs=7, rt=2 -> LO=3, HI=1.
REQ-031 SHALL be verified with: HI=0x11, LO=0x22, then divu rt=0 -> busy 10 cycles, then HI=0x11, LO=0x22.
REQ-032 SHALL be verified with: mult with cancel=1 -> md_start=0, busy stays 0, HI/LO unchanged. Then cancel=1 during BUSY of a mult -> result still commits after 5 cycles.
REQ-033 SHALL be verified with: reset asserted in cycle T+3 of a div -> busy=0 next cycle, HI=LO=0, and no change at cycle T+11.
REQ-034 SHALL be verified with: mthi 0xABCD0000 while busy -> ignored. mtlo 0x1234 when idle -> LO=0x1234 next cycle, busy stays 0. mult issued at cycle T+N+1 after a div -> accepted (md_start=1).
